// File: rtl/timer_compare_pkg.sv
// Shared timer definitions: compare FSM states and default timebase/pulse widths.
// Imported by the compare block, its interface and the capture counter.
package timer_compare_pkg;

  localparam int TIMER_WIDTH    = 32;
  localparam int TIMER_PW_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PULSE = 2'd2
  } timer_state_e;

endpackage

// File: rtl/timer_compare_if.sv
// Request/status bundle for timer_compare. Loads are accepted only while ready=1;
// there is no queueing, so the master must watch ready and err.
interface timer_compare_if #(
  parameter int WIDTH    = timer_compare_pkg::TIMER_WIDTH,
  parameter int PW_WIDTH = timer_compare_pkg::TIMER_PW_WIDTH
);

  logic                load;
  logic                cancel;
  logic [WIDTH-1:0]    target_in;
  logic [PW_WIDTH-1:0] width_in;
  logic [PW_WIDTH-1:0] period_in;
  logic [WIDTH-1:0]    count;
  logic                pulse_out;
  logic                ready;
  logic                done;
  logic                err;

  modport master (
    output load, cancel, target_in, width_in, period_in,
    input  count, pulse_out, ready, done, err
  );

  modport slave (
    input  load, cancel, target_in, width_in, period_in,
    output count, pulse_out, ready, done, err
  );

endinterface

// File: rtl/timer_pulse_ctr.sv
// Width-phase down-counter; tc is high on the last cycle of the pulse (count==1).
// Load has priority below clear; no backpressure.
module timer_pulse_ctr #(
  parameter int PW_WIDTH = timer_compare_pkg::TIMER_PW_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [PW_WIDTH-1:0] load_val,
  input  logic                clr,
  output logic                tc
);

  logic [PW_WIDTH-1:0] cnt_q;
  logic [PW_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - PW_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == PW_WIDTH'(1));

endmodule

// File: rtl/timer_compare.sv
// Free-running counter with compare-scheduled one-shot/periodic pulses; pulse rises one cycle after match.
// Loads are accepted only in IDLE (ready); loads while busy are dropped silently.
module timer_compare
  import timer_compare_pkg::*;
#(
  parameter int WIDTH    = TIMER_WIDTH,
  parameter int PW_WIDTH = TIMER_PW_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  timer_compare_if.slave   bus
);

  timer_state_e        state_q, state_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    target_q, target_d;
  logic [PW_WIDTH-1:0] width_q, width_d;
  logic [PW_WIDTH-1:0] period_q, period_d;
  logic                pulse_q, pulse_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [PW_WIDTH-1:0] eff_width;
  logic                load_bad;
  logic                match;
  logic                ctr_load;
  logic                ctr_clr;
  logic                ctr_tc;

  // A zero width still produces a one-cycle pulse.
  assign eff_width = (bus.width_in == '0) ? PW_WIDTH'(1) : bus.width_in;
  // A repeat period must leave at least one ARMED cycle between pulses.
  assign load_bad  = (bus.period_in != '0) && (bus.period_in <= eff_width);
  assign match     = (count_q == target_q);

  timer_pulse_ctr #(
    .PW_WIDTH (PW_WIDTH)
  ) u_pulse_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (width_q),
    .clr      (ctr_clr),
    .tc       (ctr_tc)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q + WIDTH'(1);
    target_d = target_q;
    width_d  = width_q;
    period_d = period_q;
    pulse_d  = pulse_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ctr_load = 1'b0;
    ctr_clr  = 1'b0;

    case (state_q)
      IDLE: begin
        pulse_d = 1'b0;
        if (bus.load) begin
          if (load_bad) begin
            err_d = 1'b1;
          end else begin
            target_d = bus.target_in;
            width_d  = eff_width;
            period_d = bus.period_in;
            state_d  = ARMED;
          end
        end
      end

      ARMED: begin
        if (bus.cancel) begin
          state_d = IDLE;
          ctr_clr = 1'b1;
        end else if (match) begin
          state_d  = PULSE;
          pulse_d  = 1'b1;
          ctr_load = 1'b1;
          // Next match is scheduled now so the rising edges stay exactly one period apart.
          if (period_q != '0) begin
            target_d = target_q + WIDTH'(period_q);
          end
        end
      end

      PULSE: begin
        if (bus.cancel) begin
          state_d = IDLE;
          pulse_d = 1'b0;
          ctr_clr = 1'b1;
        end else if (ctr_tc) begin
          pulse_d = 1'b0;
          if (period_q == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ARMED;
          end
        end
      end

      default: begin
        state_d = IDLE;
        pulse_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      target_q <= '0;
      width_q  <= '0;
      period_q <= '0;
      pulse_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      width_q  <= width_d;
      period_q <= period_d;
      pulse_q  <= pulse_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.pulse_out = pulse_q;
  assign bus.ready     = (state_q == IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_timer_compare.sv
// Directed bench for timer_compare: 32-bit instance for one-shot/repeat/error/cancel/reset,
// 8-bit instance for counter wrap behaviour.
module tb_timer_compare;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  timer_compare_if #(.WIDTH(32), .PW_WIDTH(16)) bus32 ();
  timer_compare_if #(.WIDTH(8),  .PW_WIDTH(16)) bus8 ();

  timer_compare #(.WIDTH(32), .PW_WIDTH(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32)
  );

  timer_compare #(.WIDTH(8), .PW_WIDTH(16)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned exp_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge; track the expected count.
  task automatic tick();
    logic r;
    r = reset;
    @(posedge clk);
    #1;
    exp_cnt = r ? exp_cnt + 1 : 0;
  endtask

  task automatic run_to(input int unsigned c);
    for (int i = 0; i < 2000 && exp_cnt != c; i++) tick();
  endtask

  task automatic load32(input logic [31:0] t, input logic [15:0] w, input logic [15:0] p);
    bus32.target_in = t;
    bus32.width_in  = w;
    bus32.period_in = p;
    bus32.load      = 1'b1;
    tick();
    bus32.load      = 1'b0;
  endtask

  task automatic load8(input logic [7:0] t, input logic [15:0] w, input logic [15:0] p);
    bus8.target_in = t;
    bus8.width_in  = w;
    bus8.period_in = p;
    bus8.load      = 1'b1;
    tick();
    bus8.load      = 1'b0;
  endtask

  initial begin
    bus32.load = 1'b0; bus32.cancel = 1'b0;
    bus32.target_in = '0; bus32.width_in = '0; bus32.period_in = '0;
    bus8.load = 1'b0; bus8.cancel = 1'b0;
    bus8.target_in = '0; bus8.width_in = '0; bus8.period_in = '0;

    // Reset state
    reset = 1'b0;
    tick();
    tick();
    chk("rst_count",  bus32.count, 0);
    chk("rst_pulse",  bus32.pulse_out, 0);
    chk("rst_ready",  bus32.ready, 1);
    chk("rst_done",   bus32.done, 0);
    chk("rst_err",    bus32.err, 0);
    chk("rst_count8", bus8.count, 0);
    reset = 1'b1;
    tick();
    chk("cnt_inc", bus32.count, exp_cnt);

    // One-shot: target 20, width 3 -> high at 21..23, done at 24
    run_to(10);
    load32(32'd20, 16'd3, 16'd0);
    while (exp_cnt <= 26) begin
      chk($sformatf("os_cnt@%0d", exp_cnt),   bus32.count, exp_cnt);
      chk($sformatf("os_pulse@%0d", exp_cnt), bus32.pulse_out, (exp_cnt >= 21 && exp_cnt <= 23));
      chk($sformatf("os_done@%0d", exp_cnt),  bus32.done, (exp_cnt == 24));
      chk($sformatf("os_ready@%0d", exp_cnt), bus32.ready, (exp_cnt >= 24));
      tick();
    end

    // Repeat: target 100, width 2, period 10; a load while ARMED is ignored
    run_to(30);
    load32(32'd100, 16'd2, 16'd10);
    while (exp_cnt <= 135) begin
      chk($sformatf("rp_pulse@%0d", exp_cnt), bus32.pulse_out,
          (exp_cnt >= 101) && (((exp_cnt - 101) % 10) < 2));
      chk($sformatf("rp_done@%0d", exp_cnt),  bus32.done, 0);
      chk($sformatf("rp_ready@%0d", exp_cnt), bus32.ready, 0);
      if (exp_cnt == 51) chk("rp_ign_err", bus32.err, 0);
      if (exp_cnt == 50) begin
        bus32.target_in = 32'd60;
        bus32.width_in  = 16'd5;
        bus32.period_in = 16'd0;
        bus32.load      = 1'b1;
      end else begin
        bus32.load = 1'b0;
      end
      tick();
    end
    bus32.cancel = 1'b1;
    tick();
    bus32.cancel = 1'b0;
    while (exp_cnt <= 146) begin
      chk($sformatf("rpc_pulse@%0d", exp_cnt), bus32.pulse_out, 0);
      chk($sformatf("rpc_ready@%0d", exp_cnt), bus32.ready, 1);
      chk($sformatf("rpc_done@%0d", exp_cnt),  bus32.done, 0);
      tick();
    end

    // Rejected loads: period==width, and period 1 with zero width (effective width 1)
    run_to(150);
    load32(32'd170, 16'd3, 16'd3);
    chk("err_p3w3",   bus32.err, 1);
    chk("err_ready",  bus32.ready, 1);
    load32(32'd170, 16'd0, 16'd1);
    chk("err_once",   bus32.err, 1);
    chk("err_ready2", bus32.ready, 1);
    tick();
    chk("err_clear",  bus32.err, 0);

    // Zero width -> one-cycle pulse
    run_to(160);
    load32(32'd170, 16'd0, 16'd0);
    while (exp_cnt <= 175) begin
      chk($sformatf("zw_pulse@%0d", exp_cnt), bus32.pulse_out, (exp_cnt == 171));
      chk($sformatf("zw_done@%0d", exp_cnt),  bus32.done, (exp_cnt == 172));
      tick();
    end

    // Cancel mid-pulse (width 5), asserted during count 193
    run_to(180);
    load32(32'd190, 16'd5, 16'd0);
    while (exp_cnt <= 200) begin
      chk($sformatf("cn_pulse@%0d", exp_cnt), bus32.pulse_out, (exp_cnt >= 191 && exp_cnt <= 193));
      chk($sformatf("cn_done@%0d", exp_cnt),  bus32.done, 0);
      chk($sformatf("cn_ready@%0d", exp_cnt), bus32.ready, (exp_cnt >= 194));
      bus32.cancel = (exp_cnt == 193);
      tick();
    end
    bus32.cancel = 1'b0;

    // Load coincident with cancel in IDLE is accepted
    run_to(205);
    bus32.cancel = 1'b1;
    load32(32'd210, 16'd1, 16'd0);
    bus32.cancel = 1'b0;
    chk("lc_ready", bus32.ready, 0);
    while (exp_cnt <= 214) begin
      chk($sformatf("lc_pulse@%0d", exp_cnt), bus32.pulse_out, (exp_cnt == 211));
      chk($sformatf("lc_done@%0d", exp_cnt),  bus32.done, (exp_cnt == 212));
      tick();
    end

    // Reset in the middle of a pulse
    run_to(220);
    load32(32'd230, 16'd4, 16'd0);
    run_to(232);
    chk("rm_pulse_hi", bus32.pulse_out, 1);
    reset = 1'b0;
    tick();
    chk("rm_count", bus32.count, 0);
    chk("rm_pulse", bus32.pulse_out, 0);
    chk("rm_ready", bus32.ready, 1);
    chk("rm_done",  bus32.done, 0);
    chk("rm_cnt8",  bus8.count, 0);
    reset = 1'b1;
    tick();
    chk("rm_count1", bus32.count, 1);
    chk("rm_pulse1", bus32.pulse_out, 0);

    // 8-bit wrap: load at 250, target 5 -> rises at count 6 after wrap
    run_to(250);
    load8(8'd5, 16'd1, 16'd0);
    chk("wr_ready", bus8.ready, 0);
    while (exp_cnt <= 265) begin
      chk($sformatf("wr_cnt@%0d", exp_cnt),   bus8.count, exp_cnt & 32'hff);
      chk($sformatf("wr_pulse@%0d", exp_cnt), bus8.pulse_out, (exp_cnt == 262));
      chk($sformatf("wr_done@%0d", exp_cnt),  bus8.done, (exp_cnt == 263));
      tick();
    end

    // Target equal to the load-cycle count matches only after a full wrap
    run_to(270);
    load8(8'd14, 16'd1, 16'd0);
    while (exp_cnt <= 530) begin
      chk($sformatf("fw_pulse@%0d", exp_cnt), bus8.pulse_out, (exp_cnt == 527));
      if (exp_cnt >= 520) chk($sformatf("fw_done@%0d", exp_cnt), bus8.done, (exp_cnt == 528));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
